// File: rtl/target_net_argmax_pkg.sv
// Shared float-format constants and reduce-mode encodings for the DQN datapath.
package dqn_fp_pkg;

    localparam int FP_EXP_WIDTH  = 8;
    localparam int FP_MANT_WIDTH = 23;
    localparam int FP_DATA_WIDTH = 1 + FP_EXP_WIDTH + FP_MANT_WIDTH;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_MIN = 1'b1
    } mode_e;

endpackage

// File: rtl/target_net_argmax_if.sv
// Element stream in, one-cycle result pulse out, for the argmax reducer.
interface target_net_argmax_if
    import dqn_fp_pkg::*;
#(
    parameter int DATA_WIDTH  = FP_DATA_WIDTH,
    parameter int INDEX_WIDTH = 2
);
    logic                   i_valid;
    logic                   i_mode;
    logic [DATA_WIDTH-1:0]  i_data;
    logic                   o_valid;
    logic [DATA_WIDTH-1:0]  o_data;
    logic [INDEX_WIDTH-1:0] o_index;

    modport master (output i_valid, i_mode, i_data, input o_valid, o_data, o_index);
    modport slave  (input i_valid, i_mode, i_data, output o_valid, o_data, o_index);
endinterface

// File: rtl/target_net_argmax_fp_total_order_cmp.sv
// Total-order compare on float bit patterns: -NaN < -inf < ... < -0 < +0 < ... < +inf < +NaN.
module fp_total_order_cmp
    import dqn_fp_pkg::*;
#(
    parameter int EXP_WIDTH  = FP_EXP_WIDTH,
    parameter int MANT_WIDTH = FP_MANT_WIDTH,
    parameter int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b,
    output logic                  a_eq_b
);
    localparam int SIGN = EXP_WIDTH + MANT_WIDTH;

    // Negatives are inverted so larger magnitude sorts lower; positives get the
    // top bit set so every positive sorts above every negative.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
        order_key = x[SIGN] ? ~x : {1'b1, x[SIGN-1:0]};
    endfunction

    assign a_gt_b = order_key(a) > order_key(b);
    assign a_eq_b = (a == b);
endmodule

// File: rtl/target_net_argmax.sv
// Streaming max/min reducer with argmax over vectors of NUMBER_OF_OUTPUT_NODE floats.
module target_net_argmax
    import dqn_fp_pkg::*;
#(
    parameter int DATA_WIDTH            = FP_DATA_WIDTH,
    parameter int EXP_WIDTH             = FP_EXP_WIDTH,
    parameter int MANT_WIDTH            = FP_MANT_WIDTH,
    parameter int NUMBER_OF_OUTPUT_NODE = 3,
    parameter int INDEX_WIDTH           = $clog2(NUMBER_OF_OUTPUT_NODE)
) (
    input logic          clk,
    input logic          rst_n,
    target_net_argmax_if.slave bus
);
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

    logic [INDEX_WIDTH-1:0] cnt;
    logic [INDEX_WIDTH-1:0] best_idx;
    logic [DATA_WIDTH-1:0]  best;
    mode_e                  mode_q;

    logic [DATA_WIDTH-1:0]  cmp_a, cmp_b;
    logic                   a_gt_b, a_eq_b;
    logic                   better;
    logic [DATA_WIDTH-1:0]  nxt_best;
    logic [INDEX_WIDTH-1:0] nxt_idx;

    // One comparator serves both modes: min mode asks "is best > new" instead.
    assign cmp_a = (mode_q == MODE_MIN) ? best : bus.i_data;
    assign cmp_b = (mode_q == MODE_MIN) ? bus.i_data : best;

    fp_total_order_cmp #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b)
    );

    // Strict improvement only, so ties keep the earlier index.
    assign better   = a_gt_b & ~a_eq_b;
    assign nxt_best = better ? bus.i_data : best;
    assign nxt_idx  = better ? cnt : best_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            best        <= '0;
            best_idx    <= '0;
            mode_q      <= MODE_MAX;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_index <= '0;
        end else begin
            bus.o_valid <= 1'b0;
            if (bus.i_valid) begin
                if (cnt == '0) begin
                    best     <= bus.i_data;
                    best_idx <= '0;
                    mode_q   <= mode_e'(bus.i_mode);
                    cnt      <= cnt + 1'b1;
                end else begin
                    best     <= nxt_best;
                    best_idx <= nxt_idx;
                    if (cnt == LAST) begin
                        bus.o_data  <= nxt_best;
                        bus.o_index <= nxt_idx;
                        bus.o_valid <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_target_net_argmax.sv
// Bench for target_net_argmax: vector table on N=3 plus an argmax position sweep at N=2,4,8.
module tb_target_net_argmax;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  idx;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [31:0] d0, d1, d2;
        logic [31:0] exp_d;
        logic [1:0]  exp_i;
        int          gap;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t mq[$];
    exp_t q2[$];
    exp_t q4[$];
    exp_t q8[$];

    logic [2:0]  sw_valid = '0;
    logic [31:0] sw_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    target_net_argmax_if #(.DATA_WIDTH(32), .INDEX_WIDTH(2)) mif();
    target_net_argmax_if #(.DATA_WIDTH(32), .INDEX_WIDTH(1)) sif2();
    target_net_argmax_if #(.DATA_WIDTH(32), .INDEX_WIDTH(2)) sif4();
    target_net_argmax_if #(.DATA_WIDTH(32), .INDEX_WIDTH(3)) sif8();

    assign sif2.i_valid = sw_valid[0];
    assign sif4.i_valid = sw_valid[1];
    assign sif8.i_valid = sw_valid[2];
    assign sif2.i_data  = sw_data;
    assign sif4.i_data  = sw_data;
    assign sif8.i_data  = sw_data;
    assign sif2.i_mode  = 1'b0;
    assign sif4.i_mode  = 1'b0;
    assign sif8.i_mode  = 1'b0;

    target_net_argmax #(.NUMBER_OF_OUTPUT_NODE(3)) dut  (.clk(clk), .rst_n(rst_n), .bus(mif.slave));
    target_net_argmax #(.NUMBER_OF_OUTPUT_NODE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(sif2.slave));
    target_net_argmax #(.NUMBER_OF_OUTPUT_NODE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(sif4.slave));
    target_net_argmax #(.NUMBER_OF_OUTPUT_NODE(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(sif8.slave));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s_pulse: got o_valid=1 expected no pending result (cycle %0d)", nm, cyc);
    endtask

    task automatic got(input string nm, input exp_t e, input logic [31:0] d, input logic [2:0] i);
        check({nm, "_data"}, 64'(d), 64'(e.d));
        check({nm, "_index"}, 64'(i), 64'(e.idx));
        check({nm, "_latency"}, 64'(cyc), 64'(e.cyc));
    endtask

    // Scoreboard: every result pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (mif.o_valid === 1'b1) begin
            if (mq.size() == 0) unexpected("main");
            else got("main", mq.pop_front(), mif.o_data, 3'(mif.o_index));
        end
        if (sif2.o_valid === 1'b1) begin
            if (q2.size() == 0) unexpected("n2");
            else got("n2", q2.pop_front(), sif2.o_data, 3'(sif2.o_index));
        end
        if (sif4.o_valid === 1'b1) begin
            if (q4.size() == 0) unexpected("n4");
            else got("n4", q4.pop_front(), sif4.o_data, 3'(sif4.o_index));
        end
        if (sif8.o_valid === 1'b1) begin
            if (q8.size() == 0) unexpected("n8");
            else got("n8", q8.pop_front(), sif8.o_data, 3'(sif8.o_index));
        end
    end

    vec_t tbl[10];

    initial begin
        logic [31:0] el;
        int t;

        tbl[0] = '{1'b0, 32'h42e26279, 32'h42f3282c, 32'h42c617e1, 32'h42f3282c, 2'd1, 3};
        tbl[1] = '{1'b0, 32'h42e26279, 32'h42f3282c, 32'h42f40000, 32'h42f40000, 2'd2, 0};
        tbl[2] = '{1'b1, 32'h42e26279, 32'h42f3282c, 32'h42c617e1, 32'h42c617e1, 2'd2, 0};
        tbl[3] = '{1'b0, 32'hc0000000, 32'hbf800000, 32'h80000000, 32'h80000000, 2'd2, 0};
        tbl[4] = '{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 2'd0, 0};
        tbl[5] = '{1'b0, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 2'd0, 0};
        tbl[6] = '{1'b1, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 2'd0, 1};
        tbl[7] = '{1'b0, 32'h7f800000, 32'h7fc00000, 32'hff800000, 32'h7fc00000, 2'd1, 0};
        tbl[8] = '{1'b1, 32'h7f800000, 32'h7fc00000, 32'hff800000, 32'hff800000, 2'd2, 0};
        tbl[9] = '{1'b1, 32'hffc00000, 32'hff800000, 32'h00000000, 32'hffc00000, 2'd0, 0};

        mif.i_valid = 1'b0;
        mif.i_mode  = 1'b0;
        mif.i_data  = '0;

        repeat (2) @(negedge clk);
        check("reset_o_valid", 64'(mif.o_valid), 64'd0);
        check("reset_o_data",  64'(mif.o_data),  64'd0);
        check("reset_o_index", 64'(mif.o_index), 64'd0);
        rst_n = 1'b1;

        // Vectors stream back to back; i_mode is inverted after element 0 to show it is ignored.
        for (int v = 0; v < 10; v++) begin
            for (int e = 0; e < 3; e++) begin
                el = (e == 0) ? tbl[v].d0 : (e == 1) ? tbl[v].d1 : tbl[v].d2;
                @(negedge clk);
                mif.i_valid = 1'b1;
                mif.i_data  = el;
                mif.i_mode  = (e == 0) ? tbl[v].mode : ~tbl[v].mode;
                if (e == 2) mq.push_back('{tbl[v].exp_d, 3'(tbl[v].exp_i), cyc + 1});
                if (e < 2) begin
                    for (int g = 0; g < tbl[v].gap; g++) begin
                        @(negedge clk);
                        mif.i_valid = 1'b0;
                        mif.i_data  = $urandom;
                        mif.i_mode  = 1'($urandom);
                    end
                end
            end
        end
        @(negedge clk);
        mif.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_o_valid", 64'(mif.o_valid), 64'd0);
        check("hold_o_data",  64'(mif.o_data),  64'h00000000ffc00000);
        check("hold_o_index", 64'(mif.o_index), 64'd0);

        // Reset with a partial vector in flight and an element offered during reset.
        @(negedge clk); mif.i_valid = 1'b1; mif.i_mode = 1'b0; mif.i_data = 32'h42f40000;
        @(negedge clk); mif.i_data = 32'h7f000000;
        @(negedge clk); rst_n = 1'b0; mif.i_data = 32'h7f7fffff;
        @(negedge clk);
        check("midrst_o_valid", 64'(mif.o_valid), 64'd0);
        check("midrst_o_data",  64'(mif.o_data),  64'd0);
        check("midrst_o_index", 64'(mif.o_index), 64'd0);
        rst_n = 1'b1;
        mif.i_valid = 1'b0;
        @(negedge clk); mif.i_valid = 1'b1; mif.i_data = 32'h42f3282c;
        @(negedge clk); mif.i_data = 32'h42c617e1;
        @(negedge clk); mif.i_data = 32'h42e26279;
        mq.push_back('{32'h42f3282c, 3'd0, cyc + 1});
        @(negedge clk); mif.i_valid = 1'b0;

        // Max placed at every position for N = 2, 4, 8.
        for (int k = 0; k < 3; k++) begin
            int n;
            n = (k == 0) ? 2 : (k == 1) ? 4 : 8;
            for (int p = 0; p < n; p++) begin
                for (int e = 0; e < n; e++) begin
                    @(negedge clk);
                    sw_valid    = '0;
                    sw_valid[k] = 1'b1;
                    if (e == p)          sw_data = 32'h42f40000;
                    else if (e % 2 == 1) sw_data = 32'hc1000000 + 32'(e);
                    else                 sw_data = 32'h3f800000 + 32'(e);
                    if (e == n - 1) begin
                        if (k == 0)      q2.push_back('{32'h42f40000, 3'(p), cyc + 1});
                        else if (k == 1) q4.push_back('{32'h42f40000, 3'(p), cyc + 1});
                        else             q8.push_back('{32'h42f40000, 3'(p), cyc + 1});
                    end
                end
            end
        end
        @(negedge clk);
        sw_valid = '0;

        t = 0;
        while ((mq.size() + q2.size() + q4.size() + q8.size()) != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(mq.size() + q2.size() + q4.size() + q8.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/target_net_argmax.md
# target_net_argmax

Streaming max/min reducer with argmax for the Q-value output layer of the DQN datapath. It takes one IEEE-754 value per `i_valid` cycle and groups every `NUMBER_OF_OUTPUT_NODE` accepted values into one vector. For each vector it emits the selected value and its node index as a one-cycle result pulse. It is the parametrised successor of the max-only target-net reducer and feeds both the target-Q computation (max) and the greedy action selector (argmax).

## Interface
- `DATA_WIDTH`, 32: total float width; equals 1 + `EXP_WIDTH` + `MANT_WIDTH`.
- `EXP_WIDTH`, 8: exponent field width.
- `MANT_WIDTH`, 23: mantissa field width.
- `NUMBER_OF_OUTPUT_NODE`, 3: elements per vector, ≥ 2.
- `INDEX_WIDTH`, `$clog2(NUMBER_OF_OUTPUT_NODE)`: width of the index output.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- `i_valid`  in  1  element strobe; `i_data` is sampled when high.
- `i_mode`  in  1  0 = max, 1 = min; sampled only with element 0 of a vector.
- `i_data`  in  `DATA_WIDTH`  element value.
- `o_valid`  out  1  one-cycle result pulse.
- `o_data`  out  `DATA_WIDTH`  selected value; held until the next result.
- `o_index`  out  `INDEX_WIDTH`  node position of the selected value; held until the next result.

## Operation
- Element counter `cnt` runs 0..N-1 and advances only on `i_valid`. Gaps of any length are allowed mid-vector; the counter and running state hold through them.
- On element 0: `best` ← `i_data`, `best_idx` ← 0, `mode_q` ← `i_mode`.
- On element k > 0: replace `best`/`best_idx` only if the new value is strictly better: greater in max mode, smaller in min mode.
- Ties keep the lower index.
- Ordering is a total order on the bit pattern:
  - sign-magnitude compare;
  - -0 < +0;
  - infinities order naturally;
  - NaNs order beyond infinities by magnitude.
  - No exceptions or flags are raised.
- On element N-1, the final compare result is written directly to `o_data`/`o_index`, `o_valid` ← 1, and `cnt` ← 0.
- States are implicit in `cnt`: IDLE/ACCUM (`cnt` = 0 with no partial vector, or 0 < `cnt` < N), then EMIT via the `o_valid` pulse.
- Reset (`rst_n` = 0 at a rising edge) sets `cnt` = 0, `best` = 0, `best_idx` = 0, `mode_q` = 0, `o_valid` = 0, `o_data` = 0, `o_index` = 0.
  - Reset mid-vector discards the partial vector.
  - An `i_valid` in the reset cycle is ignored.

## Timing
- No backpressure; the block accepts one element per cycle indefinitely.
- Latency: `o_valid` is high in the cycle immediately after the edge that sampled element N-1. Throughput is one vector per N cycles.
- `o_valid` is high for exactly one cycle per vector and is never asserted for a partial vector.
- Back-to-back vectors: element 0 of vector v+1 may arrive in the same cycle `o_valid` of vector v is high. Both are handled, with no bubble and no corruption of the held `o_data`/`o_index`.
- `i_mode` changes mid-vector have no effect until the next element 0.
- The compare path is a single combinational stage between `i_data` and the `best` register.

## Structure
- Shared package `dqn_fp_pkg` holds:
  - the float field-width constants and default `DATA_WIDTH`;
  - mode encodings `MODE_MAX` = 0, `MODE_MIN` = 1.
- Sub-module `fp_total_order_cmp` is purely combinational:
  - inputs `a`, `b`;
  - outputs `a_gt_b`, `a_eq_b`;
  - instantiated once and shared across modes by swapping operands.
- The top level holds the counter, the `best`/`best_idx`/`mode_q` registers, and the output registers.

## Test plan
- Max mode, N = 3: 42e26279, 42f3282c, 42c617e1 → `o_valid` one cycle after the third element, `o_data` = 42f3282c, `o_index` = 1. Then 42e26279, 42f3282c, 42f40000 → 42f40000, index 2.
- Min mode, same first vector → 42c617e1, index 2. Toggling `i_mode` after element 0 changes nothing.
- Signs and ties:
  - c0000000, bf800000, 80000000 max → 80000000, index 2;
  - 00000000, 80000000, 00000000 max → 00000000, index 0;
  - 3f800000 ×3 → index 0.
- Gaps and back-to-back:
  - three-cycle idle gaps between elements → same result, single pulse;
  - two vectors with continuous `i_valid` → pulses exactly N cycles apart, both correct.
- Reset mid-vector: two elements, `rst_n` low one cycle, then a full vector 42f3282c, 42c617e1, 42e26279 → no stale pulse, then 42f3282c, index 0. All outputs are 0 during reset.
- Parameter sweep: N = 2, 4, 8 with the maximum placed at each position → correct `o_index` at the full `INDEX_WIDTH`.
